count_display_driver: RTL and testbench

COUNT_DISPLAY_DRIVER -- requirements
Module: count_display_driver

---
 rtl/count_display_driver.sv | 171 +++++++++++++++++
 tb/tb_count_display_driver.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/count_display_driver.sv
// 8-bit count to 3-digit BCD (serial double-dabble) with a multiplexed, leading-zero
// blanked, active-low 7-segment scan driver.
module count_display_driver #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  count,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [11:0] bcd,
  output logic        busy,
  output logic        update
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;

  logic [1:0]        state, state_nx;
  logic [7:0]        shift_reg, shift_reg_nx;
  logic [11:0]       scratch, scratch_nx;
  logic [11:0]       adj;
  logic [2:0]        iter, iter_nx;
  logic [7:0]        latched, latched_nx;
  logic [7:0]        shown, shown_nx;
  logic              dirty, dirty_nx;
  logic [11:0]       bcd_nx;
  logic              busy_nx, update_nx;
  logic [SCAN_W-1:0] scan_cnt, scan_cnt_nx;
  logic [1:0]        digit_sel, digit_sel_nx;
  logic [3:0]        an_nx;
  logic [6:0]        seg_nx;
  logic [3:0]        digit;
  logic              blank;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  // State register; reset wins over everything else
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      iter      <= '0;
      latched   <= '0;
      shown     <= '0;
      dirty     <= 1'b1;
      bcd       <= '0;
      busy      <= 1'b0;
      update    <= 1'b0;
      scan_cnt  <= '0;
      digit_sel <= '0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      dp        <= 1'b1;
    end else begin
      state     <= state_nx;
      shift_reg <= shift_reg_nx;
      scratch   <= scratch_nx;
      iter      <= iter_nx;
      latched   <= latched_nx;
      shown     <= shown_nx;
      dirty     <= dirty_nx;
      bcd       <= bcd_nx;
      busy      <= busy_nx;
      update    <= update_nx;
      scan_cnt  <= scan_cnt_nx;
      digit_sel <= digit_sel_nx;
      an        <= an_nx;
      seg       <= seg_nx;
      dp        <= 1'b1;
    end
  end

  // Converter next-state: add-3 correction then shift, one bit per cycle
  always_comb begin
    state_nx     = state;
    shift_reg_nx = shift_reg;
    scratch_nx   = scratch;
    iter_nx      = iter;
    latched_nx   = latched;
    shown_nx     = shown;
    dirty_nx     = dirty;
    bcd_nx       = bcd;
    update_nx    = 1'b0;
    adj          = scratch;
    for (int i = 0; i < 3; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    case (state)
      IDLE: begin
        if ((count != shown) || dirty) begin
          latched_nx   = count;
          shift_reg_nx = count;
          scratch_nx   = '0;
          dirty_nx     = 1'b0;
          iter_nx      = '0;
          state_nx     = CONV;
        end
      end
      CONV: begin
        {scratch_nx, shift_reg_nx} = {adj[10:0], shift_reg, 1'b0};
        iter_nx = iter + 3'd1;
        if (iter == 3'd7) state_nx = LOAD;
      end
      LOAD: begin
        bcd_nx    = scratch;
        shown_nx  = latched;
        update_nx = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // Scan driver built from next-cycle values so pins move only with slot or bcd changes
  always_comb begin
    scan_cnt_nx  = scan_cnt + SCAN_W'(1);
    digit_sel_nx = digit_sel;
    if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_nx  = '0;
      digit_sel_nx = digit_sel + 2'd1;
    end
    an_nx = 4'b1111;
    digit = 4'd0;
    blank = 1'b1;
    case (digit_sel_nx)
      2'd0: begin
        an_nx = 4'b1110;
        digit = bcd_nx[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        if (bcd_nx[11:4] != 8'd0) begin
          an_nx = 4'b1101;
          digit = bcd_nx[7:4];
          blank = 1'b0;
        end
      end
      2'd2: begin
        if (bcd_nx[11:8] != 4'd0) begin
          an_nx = 4'b1011;
          digit = bcd_nx[11:8];
          blank = 1'b0;
        end
      end
      default: blank = 1'b1;
    endcase
    seg_nx = blank ? 7'b1111111 : glyph(digit);
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Randomized bench for count_display_driver against a cycle-counting arithmetic model.
module tb_count_display_driver;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  count;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [11:0] bcd;
  logic        busy;
  logic        update;

  count_display_driver #(.SCAN_DIV(SD)) dut (
    .clk(clk), .reset_n(reset_n), .count(count), .an(an), .seg(seg),
    .dp(dp), .bcd(bcd), .busy(busy), .update(update)
  );

  always #5 clk = ~clk;

  logic [6:0] glyphs [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: k = edges since reset, left = cycles until the pending result lands
  int          k, left, m_val, m_shown;
  bit          m_dirty, m_update, m_busy, m_in_reset;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d, count %0d)", tag, got, exp, cyc, count);
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic model_step();
    int sel, h, t, o;
    if (!reset_n) begin
      k = 0; left = 0; m_shown = 0; m_dirty = 1; m_update = 0; m_busy = 0; m_in_reset = 1;
      m_an = 4'hF; m_seg = 7'h7F;
      return;
    end
    m_in_reset = 0;
    k++;
    m_update = 0;
    if (left == 0) begin
      if (int'(count) != m_shown || m_dirty) begin
        m_val = int'(count); m_dirty = 0; left = 9;
      end
    end else begin
      left--;
      if (left == 0) begin
        m_shown = m_val; m_update = 1;
      end
    end
    m_busy = (left != 0);
    sel = (k / SD) % 4;
    h = m_shown / 100; t = (m_shown / 10) % 10; o = m_shown % 10;
    m_an = 4'hF; m_seg = 7'h7F;
    if (sel == 0) begin
      m_an = 4'b1110; m_seg = glyphs[o];
    end else if (sel == 1 && (h != 0 || t != 0)) begin
      m_an = 4'b1101; m_seg = glyphs[t];
    end else if (sel == 2 && h != 0) begin
      m_an = 4'b1011; m_seg = glyphs[h];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check("an", 16'(an), 16'(m_an));
    check("seg", 16'(seg), 16'(m_seg));
    check("dp", 16'(dp), 16'd1);
    check("bcd", 16'(bcd), 16'(to_bcd(m_in_reset ? 0 : m_shown)));
    check("busy", 16'(busy), 16'(m_busy));
    check("update", 16'(update), 16'(m_update));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hold_until_update(input logic [7:0] v);
    bit seen;
    count = v;
    seen = 0;
    for (int i = 0; i < 25 && !seen; i++) begin
      tick();
      seen = m_update;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL sweep_timeout: got no update expected update for count %0d", v);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    count   = 8'd255;
    run(2);
    reset_n = 1'b1;
    run(12);
    check("bcd_255", 16'(bcd), 16'h0255);
    run(20);

    count = 8'd7;
    run(28);
    count = 8'd100;
    run(30);
    check("bcd_100", 16'(bcd), 16'h0100);

    count = 8'd12;
    run(3);
    count = 8'd200;
    run(25);

    count = 8'd99;
    run(4);
    reset_n = 1'b0;
    run(1);
    reset_n = 1'b1;
    run(15);
    check("bcd_099", 16'(bcd), 16'h0099);

    for (int v = 0; v < 256; v++) hold_until_update(8'(v));

    for (int r = 0; r < 60; r++) begin
      count = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) begin
        reset_n = 1'b0;
        run(1);
        reset_n = 1'b1;
      end
      run($urandom_range(1, 14));
    end
    run(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
